// File: rtl/reset_seq_pkg.sv
// Shared types and helpers for the ordered reset-release controller.
// Holds the FSM state encoding, the index width and the counter-width sizing rule.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        WAIT = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam int IDX_W = 3;

    // Smallest counter width able to represent the larger of the two cycle limits.
    function automatic int min_cnt_w(input int hold_cycles, input int timeout_cycles);
        int m;
        m = (hold_cycles > timeout_cycles) ? hold_cycles : timeout_cycles;
        if (m < 1) begin
            m = 1;
        end
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/reset_seq_timer.sv
// Clear/increment cycle counter with a terminal-count compare.
// Shared by the hold phase and the per-domain ready wait.
module reset_seq_timer #(
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_inc,
    input  logic [CNT_W-1:0] i_term,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_tc
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;
    assign o_tc  = (r_cnt == i_term);

endmodule

// File: rtl/reset_sequencer.sv
// Releases NUM_DOMAINS active-low resets in index order, each gated by the
// previous domain's ready or a timeout; supports a REQ/ACK software re-sequence.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NUM_DOMAINS    = 3,
    parameter int HOLD_CYCLES    = 4,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_sw_rst_req,
    output logic                   o_sw_rst_ack,
    input  logic [NUM_DOMAINS-1:0] i_dom_ready,
    output logic [NUM_DOMAINS-1:0] o_out_rst_n,
    output logic                   o_all_up,
    output logic [NUM_DOMAINS-1:0] o_timeout_err,
    output logic [IDX_W-1:0]       o_cur_domain
);

    if (NUM_DOMAINS < 1 || NUM_DOMAINS > 8 || HOLD_CYCLES < 1 || TIMEOUT_CYCLES < 1 ||
        CNT_W < min_cnt_w(HOLD_CYCLES, TIMEOUT_CYCLES)) begin : g_bad_params
        $fatal(1, "reset_sequencer: illegal parameter set");
    end

    localparam logic [CNT_W-1:0] HOLD_TERM = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_TERM  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DOMAINS - 1);

    state_t                 r_state;
    state_t                 w_state_next;
    logic [NUM_DOMAINS-1:0] r_out_rst_n;
    logic [NUM_DOMAINS-1:0] w_out_next;
    logic                   r_all_up;
    logic                   w_all_up_next;
    logic                   r_ack;
    logic                   w_ack_next;
    logic [NUM_DOMAINS-1:0] r_err;
    logic [NUM_DOMAINS-1:0] w_err_next;
    logic [IDX_W-1:0]       r_idx;
    logic [IDX_W-1:0]       w_idx_next;
    logic                   r_sw_seq;
    logic                   w_sw_seq_next;

    logic                   w_cnt_clr;
    logic                   w_cnt_inc;
    logic [CNT_W-1:0]       w_term;
    logic [CNT_W-1:0]       w_cnt;
    logic                   w_tc;
    logic [NUM_DOMAINS-1:0] w_idx_hit;
    logic [NUM_DOMAINS-1:0] w_next_hit;
    logic                   w_rdy;

    // One-hot decode of the current domain and of the domain released next.
    for (genvar gi = 0; gi < NUM_DOMAINS; gi++) begin : g_dom
        assign w_idx_hit[gi] = (r_idx == IDX_W'(gi));
        if (gi == 0) begin : g_first
            assign w_next_hit[gi] = 1'b0;
        end else begin : g_rest
            assign w_next_hit[gi] = (r_idx == IDX_W'(gi - 1));
        end
    end

    assign w_rdy  = |(w_idx_hit & i_dom_ready);
    assign w_term = (r_state == HOLD) ? HOLD_TERM : TMO_TERM;

    reset_seq_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (w_cnt_clr),
        .i_inc   (w_cnt_inc),
        .i_term  (w_term),
        .o_cnt   (w_cnt),
        .o_tc    (w_tc)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= HOLD;
            r_out_rst_n <= '0;
            r_all_up    <= 1'b0;
            r_ack       <= 1'b0;
            r_err       <= '0;
            r_idx       <= '0;
            r_sw_seq    <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_out_rst_n <= w_out_next;
            r_all_up    <= w_all_up_next;
            r_ack       <= w_ack_next;
            r_err       <= w_err_next;
            r_idx       <= w_idx_next;
            r_sw_seq    <= w_sw_seq_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_out_next    = r_out_rst_n;
        w_all_up_next = r_all_up;
        w_ack_next    = r_ack;
        w_err_next    = r_err;
        w_idx_next    = r_idx;
        w_sw_seq_next = r_sw_seq;
        w_cnt_clr     = 1'b0;
        w_cnt_inc     = 1'b0;

        case (r_state)
            HOLD: begin
                if (w_tc) begin
                    w_out_next[0] = 1'b1;
                    w_cnt_clr     = 1'b1;
                    w_idx_next    = '0;
                    w_state_next  = WAIT;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            WAIT: begin
                if (w_rdy || w_tc) begin
                    if (!w_rdy) begin
                        w_err_next = r_err | w_idx_hit;
                    end
                    if (r_idx != LAST_IDX) begin
                        w_out_next = r_out_rst_n | w_next_hit;
                        w_idx_next = r_idx + IDX_W'(1);
                        w_cnt_clr  = 1'b1;
                    end else begin
                        w_all_up_next = 1'b1;
                        w_state_next  = RUN;
                        // Only a software-initiated sequence is acknowledged.
                        if (r_sw_seq) begin
                            w_ack_next    = 1'b1;
                            w_sw_seq_next = 1'b0;
                        end
                    end
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            RUN: begin
                if (i_sw_rst_req && !r_ack) begin
                    w_out_next    = '0;
                    w_all_up_next = 1'b0;
                    w_err_next    = '0;
                    w_cnt_clr     = 1'b1;
                    w_idx_next    = '0;
                    w_state_next  = HOLD;
                    w_sw_seq_next = 1'b1;
                end else if (!i_sw_rst_req && r_ack) begin
                    w_ack_next = 1'b0;
                end
            end
            default: begin
                w_state_next = HOLD;
            end
        endcase
    end

    assign o_out_rst_n   = r_out_rst_n;
    assign o_all_up      = r_all_up;
    assign o_sw_rst_ack  = r_ack;
    assign o_timeout_err = r_err;
    assign o_cur_domain  = r_idx;

endmodule

// File: tb/tb_reset_sequencer.sv
// Randomized check of reset_sequencer against an event-time model: release edge of
// each domain is derived arithmetically from HOLD, TIMEOUT and the ready pattern.
module tb_reset_sequencer;

    localparam int NA  = 3;
    localparam int HA  = 4;
    localparam int TA  = 16;
    localparam int NB  = 1;
    localparam int HB  = 1;
    localparam int TBC = 1;
    localparam int BIG = 1000000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_a;
    logic [2:0] rdy_a;
    logic       ack_a;
    logic [2:0] out_a;
    logic       all_a;
    logic [2:0] err_a;
    logic [2:0] cur_a;
    logic       req_b;
    logic [0:0] rdy_b;
    logic       ack_b;
    logic [0:0] out_b;
    logic       all_b;
    logic [0:0] err_b;
    logic [2:0] cur_b;

    int         ka;
    int         kb;
    int         drop_k;
    logic [7:0] ctx_rdy;
    bit         ctx_sw;
    bit         restart;
    int         n_checks;
    int         n_pass;
    int         n_fail;

    always #5 clk = ~clk;

    reset_sequencer #(
        .NUM_DOMAINS    (NA),
        .HOLD_CYCLES    (HA),
        .TIMEOUT_CYCLES (TA),
        .CNT_W          (8)
    ) dut_a (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_sw_rst_req  (req_a),
        .o_sw_rst_ack  (ack_a),
        .i_dom_ready   (rdy_a),
        .o_out_rst_n   (out_a),
        .o_all_up      (all_a),
        .o_timeout_err (err_a),
        .o_cur_domain  (cur_a)
    );

    reset_sequencer #(
        .NUM_DOMAINS    (NB),
        .HOLD_CYCLES    (HB),
        .TIMEOUT_CYCLES (TBC),
        .CNT_W          (1)
    ) dut_b (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_sw_rst_req  (req_b),
        .o_sw_rst_ack  (ack_b),
        .i_dom_ready   (rdy_b),
        .o_out_rst_n   (out_b),
        .o_all_up      (all_b),
        .o_timeout_err (err_b),
        .o_cur_domain  (cur_b)
    );

    // Edge (relative to sequence start) at which ALL_UP rises.
    function automatic int t_all(input int n, input int h, input int to, input logic [7:0] r);
        int t;
        t = h;
        for (int i = 0; i < n; i++) begin
            t = t + (r[i] ? 1 : to);
        end
        return t;
    endfunction

    function automatic void model(input int n, input int h, input int to, input logic [7:0] r,
                                  input bit sw, input int k, input int drop,
                                  output logic [7:0] e_out, output logic e_all,
                                  output logic [7:0] e_err, output logic e_ack,
                                  output logic [7:0] e_cur);
        int t;
        int tn;
        int released;
        t        = h;
        released = 0;
        e_out    = '0;
        e_err    = '0;
        for (int i = 0; i < n; i++) begin
            if (k >= t) begin
                e_out[i] = 1'b1;
                released++;
            end
            tn = t + (r[i] ? 1 : to);
            if (!r[i] && k >= tn) begin
                e_err[i] = 1'b1;
            end
            t = tn;
        end
        e_all = (k >= t);
        e_ack = sw && e_all && (k < drop);
        e_cur = (released > 0) ? 8'(released - 1) : 8'd0;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s ka=%0d kb=%0d observed=%0h expected=%0h", tag, ka, kb, obs, exp);
        end
    endtask

    task automatic check_now();
        logic [7:0] eo;
        logic [7:0] ee;
        logic [7:0] ec;
        logic       eall;
        logic       eack;
        model(NA, HA, TA, ctx_rdy, ctx_sw, ka, drop_k, eo, eall, ee, eack, ec);
        chk("a_out_rst_n",   {5'b0, out_a}, eo);
        chk("a_all_up",      {7'b0, all_a}, {7'b0, eall});
        chk("a_timeout_err", {5'b0, err_a}, ee);
        chk("a_sw_ack",      {7'b0, ack_a}, {7'b0, eack});
        chk("a_cur_domain",  {5'b0, cur_a}, ec);
        model(NB, HB, TBC, 8'h00, 1'b0, kb, BIG, eo, eall, ee, eack, ec);
        chk("b_out_rst_n",   {7'b0, out_b}, eo);
        chk("b_all_up",      {7'b0, all_b}, {7'b0, eall});
        chk("b_timeout_err", {7'b0, err_b}, ee);
        chk("b_sw_ack",      {7'b0, ack_b}, {7'b0, eack});
        chk("b_cur_domain",  {5'b0, cur_b}, ec);
    endtask

    task automatic tick();
        @(posedge clk);
        if (restart) begin
            ka      = 0;
            restart = 0;
        end else begin
            ka++;
        end
        kb++;
        @(negedge clk);
        check_now();
    endtask

    task automatic run_to(input int k_end);
        while (ka < k_end) begin
            tick();
        end
    endtask

    task automatic sw_seq(input logic [2:0] r, input int extra);
        rdy_a   = r;
        ctx_rdy = {5'b0, r};
        ctx_sw  = 1'b1;
        drop_k  = BIG;
        req_a   = 1'b1;
        restart = 1'b1;
        tick();
        run_to(t_all(NA, HA, TA, ctx_rdy) + extra);
        req_a  = 1'b0;
        drop_k = ka + 1;
        run_to(ka + 2);
        $display("sw sequence ready=%b extra=%0d done at ka=%0d", r, extra, ka);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] r;
        n_checks = 0;
        n_pass   = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        req_a    = 1'b0;
        req_b    = 1'b0;
        rdy_a    = 3'b111;
        rdy_b    = 1'b0;
        ctx_rdy  = 8'h07;
        ctx_sw   = 1'b0;
        drop_k   = BIG;
        ka       = 0;
        kb       = 0;
        restart  = 1'b0;

        repeat (2) @(negedge clk);
        check_now();
        $display("reset state checked");

        rst_n = 1'b1;
        run_to(t_all(NA, HA, TA, ctx_rdy) + 3);
        $display("power-up ready=111 done at ka=%0d", ka);

        sw_seq(3'b101, 20);
        sw_seq(3'b111, 2);
        for (int i = 0; i < 6; i++) begin
            r = 3'($urandom);
            sw_seq(r, int'($urandom_range(0, 4)));
        end

        // Asynchronous reset pulse while waiting on domain 0, away from any clock edge.
        rdy_a   = 3'b110;
        ctx_rdy = 8'h06;
        ctx_sw  = 1'b1;
        drop_k  = BIG;
        req_a   = 1'b1;
        restart = 1'b1;
        tick();
        run_to(HA + 5);
        #2;
        rst_n = 1'b0;
        req_a = 1'b0;
        #1;
        chk("async_a_out_rst_n", {5'b0, out_a}, 8'h00);
        chk("async_a_all_up",    {7'b0, all_a}, 8'h00);
        chk("async_a_sw_ack",    {7'b0, ack_a}, 8'h00);
        chk("async_a_err",       {5'b0, err_a}, 8'h00);
        chk("async_b_out_rst_n", {7'b0, out_b}, 8'h00);
        chk("async_b_all_up",    {7'b0, all_b}, 8'h00);
        $display("async reset pulse checked");
        rst_n   = 1'b1;
        ka      = 0;
        kb      = 0;
        rdy_a   = 3'b101;
        ctx_rdy = 8'h05;
        ctx_sw  = 1'b0;

        // Request raised while waiting on domain 1 must wait for the sequence to finish.
        run_to(HA + 3);
        req_a = 1'b1;
        run_to(t_all(NA, HA, TA, ctx_rdy));
        rdy_a   = 3'b111;
        ctx_rdy = 8'h07;
        ctx_sw  = 1'b1;
        drop_k  = BIG;
        restart = 1'b1;
        tick();
        run_to(t_all(NA, HA, TA, ctx_rdy) + 2);
        req_a  = 1'b0;
        drop_k = ka + 1;
        run_to(ka + 3);
        $display("request-during-wait sequence done at ka=%0d", ka);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
